delay_bank: RTL and testbench

Multi-channel programmable delay timer and the parametrised successor of the single-channel millisecond delay. It provides CHANNELS independent timers, each counting a programmable number of time units of TICKS_PER_UNIT clock cycles. Each channel runs one-shot or periodic, can be cancelled, and reports both a level `busy` and a one-cycle `expire` pulse. It sits beside the game-logic FSMs for movement pacing, debounce windows and animation frames.

---
 rtl/delay_pkg.sv | 9 +
 rtl/delay_channel.sv | 82 ++++++++
 rtl/delay_bank.sv | 36 +++
 tb/tb_delay_bank.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/delay_pkg.sv
// delay_pkg: shared state type, tick-counter width helper and default constants for delay_bank.
package delay_pkg;
  typedef enum logic {IDLE, RUN} state_t;
  localparam int TICKS_PER_UNIT_DEFAULT = 2000;
  localparam int CNT_W_DEFAULT = 8;
  function automatic int tick_w(input int ticks);
    return ticks > 1 ? $clog2(ticks) : 1;
  endfunction
endpackage

// File: rtl/delay_channel.sv
// delay_channel: one programmable delay timer; periodic mode built only with DELAY_BANK_PERIODIC_EN.
module delay_channel
  import delay_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT,
  parameter int TICKS_PER_UNIT = TICKS_PER_UNIT_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] value,
  input  logic             periodic,
  input  logic             cancel,
  output logic             busy,
  output logic             expire
);
  localparam int TW = tick_w(TICKS_PER_UNIT);
  localparam logic [TW-1:0] TICK_MAX = TW'(TICKS_PER_UNIT - 1);
  state_t state, state_n;
  logic [CNT_W-1:0] unit_cnt, unit_n;
  logic [TW-1:0] tick_cnt, tick_n;
  logic expire_n;
`ifdef DELAY_BANK_PERIODIC_EN
  logic mode;
  logic [CNT_W-1:0] reload;
  always_ff @(posedge clk) begin
    if (rst) begin
      mode <= 1'b0;
      reload <= '0;
    end else if (load && !cancel) begin
      mode <= periodic;
      reload <= value;
    end
  end
`else
  logic unused_periodic;
  assign unused_periodic = periodic;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      unit_cnt <= '0;
      tick_cnt <= '0;
      expire <= 1'b0;
    end else begin
      state <= state_n;
      unit_cnt <= unit_n;
      tick_cnt <= tick_n;
      expire <= expire_n;
    end
  end
  always_comb begin
    state_n = state;
    unit_n = unit_cnt;
    tick_n = tick_cnt;
    expire_n = 1'b0;
    if (cancel) begin
      state_n = IDLE;
    end else if (load) begin
      state_n = value != '0 ? RUN : IDLE;
      unit_n = value;
      tick_n = TICK_MAX;
    end else if (state == RUN) begin
      if (tick_cnt != '0) begin
        tick_n = tick_cnt - 1'b1;
      end else if (unit_cnt > CNT_W'(1)) begin
        unit_n = unit_cnt - 1'b1;
        tick_n = TICK_MAX;
      end else begin
        expire_n = 1'b1;
        tick_n = TICK_MAX;
`ifdef DELAY_BANK_PERIODIC_EN
        state_n = mode ? RUN : IDLE;
        unit_n = mode ? reload : unit_cnt;
`else
        state_n = IDLE;
`endif
      end
    end
  end
  assign busy = state == RUN;
endmodule

// File: rtl/delay_bank.sv
// delay_bank: CHANNELS independent delay timers addressed by set_ch; periodic mode needs DELAY_BANK_PERIODIC_EN.
module delay_bank
  import delay_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int CNT_W = CNT_W_DEFAULT,
  parameter int TICKS_PER_UNIT = TICKS_PER_UNIT_DEFAULT,
  localparam int CH_W = CHANNELS > 1 ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                set,
  input  logic [CH_W-1:0]     set_ch,
  input  logic [CNT_W-1:0]    value,
  input  logic                periodic,
  input  logic [CHANNELS-1:0] cancel,
  output logic [CHANNELS-1:0] busy,
  output logic [CHANNELS-1:0] expire
);
  // out-of-range set_ch matches no index, so such a set is dropped
  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    delay_channel #(
      .CNT_W(CNT_W),
      .TICKS_PER_UNIT(TICKS_PER_UNIT)
    ) u_ch (
      .clk(clk),
      .rst(rst),
      .load(set && set_ch == CH_W'(i)),
      .value(value),
      .periodic(periodic),
      .cancel(cancel[i]),
      .busy(busy[i]),
      .expire(expire[i])
    );
  end
endmodule

// File: tb/tb_delay_bank.sv
// tb_delay_bank: directed checks of delay_bank with TICKS_PER_UNIT=4, plus a 3-channel copy for set_ch range.
module tb_delay_bank;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic set = 1'b0;
  logic [1:0] set_ch = '0;
  logic [7:0] value = '0;
  logic periodic = 1'b0;
  logic [3:0] cancel = '0;
  logic [3:0] busy, expire;
  logic set3 = 1'b0;
  logic [1:0] ch3 = '0;
  logic [2:0] busy3, expire3;
  int n_cmp = 0;
  int n_bad = 0;
  int n;
  logic late;
  typedef struct {
    logic       s;
    logic [1:0] ch;
    logic [7:0] v;
    logic [3:0] b;
    logic [3:0] e;
  } vec_t;
  vec_t tbl [0:20];

  always #5 clk = ~clk;

  delay_bank #(.CHANNELS(4), .CNT_W(8), .TICKS_PER_UNIT(4)) dut (
    .clk(clk), .rst(rst), .set(set), .set_ch(set_ch), .value(value),
    .periodic(periodic), .cancel(cancel), .busy(busy), .expire(expire)
  );

  delay_bank #(.CHANNELS(3), .CNT_W(8), .TICKS_PER_UNIT(4)) dut3 (
    .clk(clk), .rst(rst), .set(set3), .set_ch(ch3), .value(value),
    .periodic(1'b0), .cancel(3'b000), .busy(busy3), .expire(expire3)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_set(input int c, input int v, input logic p);
    set = 1'b1;
    set_ch = 2'(c);
    value = 8'(v);
    periodic = p;
    step();
    set = 1'b0;
    periodic = 1'b0;
  endtask

  task automatic count_exp(input int c, input int lim, output int cyc);
    cyc = -1;
    for (int i = 1; i <= lim; i++) begin
      step();
      if (expire[c]) begin
        cyc = i;
        break;
      end
    end
  endtask

  initial begin
    tbl = '{
      '{1'b1, 2'd0, 8'd1, 4'b0001, 4'b0000},
      '{1'b1, 2'd1, 8'd2, 4'b0011, 4'b0000},
      '{1'b1, 2'd2, 8'd3, 4'b0111, 4'b0000},
      '{1'b1, 2'd3, 8'd4, 4'b1111, 4'b0000},
      '{1'b0, 2'd0, 8'd0, 4'b1110, 4'b0001},
      '{1'b0, 2'd0, 8'd0, 4'b1110, 4'b0000},
      '{1'b0, 2'd0, 8'd0, 4'b1110, 4'b0000},
      '{1'b0, 2'd0, 8'd0, 4'b1110, 4'b0000},
      '{1'b0, 2'd0, 8'd0, 4'b1110, 4'b0000},
      '{1'b0, 2'd0, 8'd0, 4'b1100, 4'b0010},
      '{1'b0, 2'd0, 8'd0, 4'b1100, 4'b0000},
      '{1'b0, 2'd0, 8'd0, 4'b1100, 4'b0000},
      '{1'b0, 2'd0, 8'd0, 4'b1100, 4'b0000},
      '{1'b0, 2'd0, 8'd0, 4'b1100, 4'b0000},
      '{1'b0, 2'd0, 8'd0, 4'b1000, 4'b0100},
      '{1'b0, 2'd0, 8'd0, 4'b1000, 4'b0000},
      '{1'b0, 2'd0, 8'd0, 4'b1000, 4'b0000},
      '{1'b0, 2'd0, 8'd0, 4'b1000, 4'b0000},
      '{1'b0, 2'd0, 8'd0, 4'b1000, 4'b0000},
      '{1'b0, 2'd0, 8'd0, 4'b0000, 4'b1000},
      '{1'b0, 2'd0, 8'd0, 4'b0000, 4'b0000}
    };
    step();
    step();
    rst = 1'b0;
    chk("reset_busy", 32'(busy), 32'h0);
    chk("reset_expire", 32'(expire), 32'h0);
    step();
    chk("idle_busy", 32'(busy), 32'h0);

    // one-shot: 3 units of 4 ticks
    do_set(0, 3, 1'b0);
    chk("oneshot_busy_start", 32'(busy[0]), 32'h1);
    count_exp(0, 20, n);
    chk("oneshot_latency", 32'(n), 32'd12);
    chk("oneshot_busy_fall", 32'(busy[0]), 32'h0);
    step();
    chk("oneshot_pulse_width", 32'(expire[0]), 32'h0);

    // periodic
    do_set(1, 2, 1'b1);
    count_exp(1, 20, n);
    chk("periodic_first", 32'(n), 32'd8);
`ifdef DELAY_BANK_PERIODIC_EN
    chk("periodic_busy_kept", 32'(busy[1]), 32'h1);
    count_exp(1, 20, n);
    chk("periodic_second", 32'(n), 32'd8);
    count_exp(1, 20, n);
    chk("periodic_third", 32'(n), 32'd8);
`else
    chk("periodic_busy_kept", 32'(busy[1]), 32'h0);
    count_exp(1, 20, n);
    chk("periodic_second", n, -1);
`endif
    cancel = 4'b0010;
    step();
    cancel = 4'b0000;
    chk("periodic_cancel_busy", 32'(busy[1]), 32'h0);
    count_exp(1, 20, n);
    chk("periodic_after_cancel", n, -1);

    // retrigger
    do_set(2, 5, 1'b0);
    for (int i = 0; i < 9; i++) step();
    do_set(2, 1, 1'b0);
    count_exp(2, 10, n);
    chk("retrigger_latency", 32'(n), 32'd4);
    count_exp(2, 30, n);
    chk("retrigger_no_old", n, -1);

    // cancel sampled on the expiry edge
    do_set(3, 1, 1'b0);
    for (int i = 0; i < 3; i++) step();
    cancel = 4'b1000;
    step();
    cancel = 4'b0000;
    chk("collide_cancel_expire", 32'(expire[3]), 32'h0);
    chk("collide_cancel_busy", 32'(busy[3]), 32'h0);
    count_exp(3, 10, n);
    chk("collide_cancel_none", n, -1);

    // set sampled on the expiry edge
    do_set(3, 1, 1'b0);
    for (int i = 0; i < 3; i++) step();
    do_set(3, 2, 1'b0);
    chk("collide_set_expire", 32'(expire[3]), 32'h0);
    chk("collide_set_busy", 32'(busy[3]), 32'h1);
    count_exp(3, 20, n);
    chk("collide_set_restart", 32'(n), 32'd8);

    // zero load
    do_set(0, 0, 1'b0);
    chk("zero_busy", 32'(busy[0]), 32'h0);
    count_exp(0, 10, n);
    chk("zero_no_expire", n, -1);
    do_set(0, 3, 1'b0);
    step();
    do_set(0, 0, 1'b0);
    chk("zero_cancels_busy", 32'(busy[0]), 32'h0);
    count_exp(0, 20, n);
    chk("zero_cancels_expire", n, -1);

    // range on a 3-channel bank
    set3 = 1'b1;
    ch3 = 2'd3;
    value = 8'd1;
    step();
    set3 = 1'b0;
    chk("range_busy", 32'(busy3), 32'h0);
    for (int i = 0; i < 6; i++) step();
    chk("range_expire", 32'(expire3), 32'h0);
    set3 = 1'b1;
    ch3 = 2'd2;
    step();
    set3 = 1'b0;
    chk("range_valid_busy", 32'(busy3), 32'h4);

    // independence: staggered sets, per-cycle expectations
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 21; i++) begin
      set = tbl[i].s;
      set_ch = tbl[i].ch;
      value = tbl[i].v;
      step();
      chk($sformatf("indep_busy_%0d", i), 32'(busy), 32'(tbl[i].b));
      chk($sformatf("indep_expire_%0d", i), 32'(expire), 32'(tbl[i].e));
    end
    set = 1'b0;

    // reset mid-count
    do_set(0, 10, 1'b0);
    do_set(1, 10, 1'b1);
    do_set(2, 10, 1'b0);
    do_set(3, 10, 1'b1);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_busy", 32'(busy), 32'h0);
    chk("midrst_expire", 32'(expire), 32'h0);
    late = 1'b0;
    for (int i = 0; i < 60; i++) begin
      step();
      if (expire != 4'b0 || busy != 4'b0) late = 1'b1;
    end
    chk("midrst_no_late", 32'(late), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
